// File: rtl/pn_acq_ctrl.sv
// PN code acquisition controller: serial search, verify, and lock monitoring with phase-load strobes.
// Optional macro PN_DLL_TRACK_EN enables early/late delay-lock corrections while in TRACK.
module pn_acq_ctrl #(
   parameter int PIPE_COMP   = 5,
   parameter int SEARCH_STEP = 4,
   parameter int VERIFY_N    = 3,
   parameter int LOSS_N      = 4,
   parameter int DEAD_BAND   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] thresh,
   input  logic [7:0]  addr_pn,
   input  logic        corr_valid,
   input  logic [15:0] e_pre,
   input  logic [15:0] e_mid,
   input  logic [15:0] e_aft,
   output logic        load,
   output logic [7:0]  addr_load,
   output logic        locked,
   output logic [1:0]  state,
   output logic        search_wrap
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_VERIFY = 2'd2,
      ST_TRACK  = 2'd3
   } state_t;

`ifdef PN_DLL_TRACK_EN
   localparam logic DLL_EN = 1'b1;
`else
   localparam logic DLL_EN = 1'b0;
`endif

   localparam logic [5:0]  WRAP_CNT = 6'(248 / SEARCH_STEP);
   localparam logic [7:0]  PIPE_C   = 8'(PIPE_COMP);
   localparam logic [7:0]  STEP_C   = 8'(SEARCH_STEP);
   localparam logic [7:0]  VERIFY_C = 8'(VERIFY_N);
   localparam logic [7:0]  LOSS_C   = 8'(LOSS_N);
   localparam logic [16:0] BAND_C   = 17'(DEAD_BAND);

   // Both operands are already in 0..247, so one conditional subtract keeps the result in range.
   function automatic logic [7:0] add_mod248(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= 9'd248) begin
         sum = sum - 9'd248;
      end else begin
         sum = sum;
      end
      return sum[7:0];
   endfunction

   state_t      state_r, state_nxt_s;
   logic [5:0]  slip_cnt_r, slip_cnt_nxt_s;
   logic [7:0]  hit_cnt_r, hit_cnt_nxt_s;
   logic [7:0]  loss_cnt_r, loss_cnt_nxt_s;
   logic        blank_r, blank_nxt_s;
   logic        load_r, load_nxt_s;
   logic [7:0]  addr_load_r, addr_load_nxt_s;
   logic        locked_r, locked_nxt_s;
   logic        wrap_r, wrap_nxt_s;
   logic        hit_s, act_s, adv_s, ret_s, slip_req_s;
   logic [7:0]  slip_d_s;

   // Next-state, counters and load request, evaluated once per strobe.
   always_comb begin
      state_nxt_s     = state_r;
      slip_cnt_nxt_s  = slip_cnt_r;
      hit_cnt_nxt_s   = hit_cnt_r;
      loss_cnt_nxt_s  = loss_cnt_r;
      blank_nxt_s     = blank_r;
      addr_load_nxt_s = addr_load_r;
      load_nxt_s      = 1'b0;
      wrap_nxt_s      = 1'b0;
      slip_req_s      = 1'b0;
      slip_d_s        = 8'd0;
      hit_s = (e_mid >= thresh);
      act_s = corr_valid & ~blank_r;
      adv_s = DLL_EN & ({1'b0, e_pre} > ({1'b0, e_aft} + BAND_C));
      ret_s = DLL_EN & ({1'b0, e_aft} > ({1'b0, e_pre} + BAND_C));

      if (!enable) begin
         state_nxt_s    = ST_IDLE;
         slip_cnt_nxt_s = 6'd0;
         hit_cnt_nxt_s  = 8'd0;
         loss_cnt_nxt_s = 8'd0;
         blank_nxt_s    = 1'b0;
      end else begin
         // A strobe arriving while blanked only consumes the blanking flag.
         if (corr_valid) begin
            blank_nxt_s = 1'b0;
         end else begin
            blank_nxt_s = blank_r;
         end
         case (state_r)
            ST_IDLE: begin
               state_nxt_s    = ST_SEARCH;
               slip_cnt_nxt_s = 6'd0;
               hit_cnt_nxt_s  = 8'd0;
               loss_cnt_nxt_s = 8'd0;
               blank_nxt_s    = 1'b0;
            end
            ST_SEARCH: begin
               if (act_s && hit_s) begin
                  state_nxt_s   = ST_VERIFY;
                  hit_cnt_nxt_s = 8'd1;
               end else if (act_s) begin
                  slip_req_s = 1'b1;
                  slip_d_s   = STEP_C;
                  if (slip_cnt_r + 6'd1 == WRAP_CNT) begin
                     wrap_nxt_s     = 1'b1;
                     slip_cnt_nxt_s = 6'd0;
                  end else begin
                     slip_cnt_nxt_s = slip_cnt_r + 6'd1;
                  end
               end else begin
                  state_nxt_s = state_r;
               end
            end
            ST_VERIFY: begin
               if (act_s && hit_s) begin
                  hit_cnt_nxt_s = hit_cnt_r + 8'd1;
                  if (hit_cnt_r + 8'd1 == VERIFY_C) begin
                     state_nxt_s    = ST_TRACK;
                     loss_cnt_nxt_s = 8'd0;
                  end else begin
                     state_nxt_s = ST_VERIFY;
                  end
               end else if (act_s) begin
                  state_nxt_s = ST_SEARCH;
                  slip_req_s  = 1'b1;
                  slip_d_s    = STEP_C;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            ST_TRACK: begin
               if (act_s && !hit_s && (loss_cnt_r + 8'd1 == LOSS_C)) begin
                  state_nxt_s    = ST_SEARCH;
                  loss_cnt_nxt_s = 8'd0;
                  slip_req_s     = 1'b1;
                  slip_d_s       = STEP_C;
               end else if (act_s) begin
                  loss_cnt_nxt_s = hit_s ? 8'd0 : loss_cnt_r + 8'd1;
                  // Loss takes priority above; only then is the delay-lock correction issued.
                  if (adv_s) begin
                     slip_req_s = 1'b1;
                     slip_d_s   = 8'd1;
                  end else if (ret_s) begin
                     slip_req_s = 1'b1;
                     slip_d_s   = 8'd247;
                  end else begin
                     slip_req_s = 1'b0;
                  end
               end else begin
                  state_nxt_s = state_r;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end

      if (slip_req_s) begin
         load_nxt_s      = 1'b1;
         addr_load_nxt_s = add_mod248(add_mod248(addr_pn, PIPE_C), slip_d_s);
         blank_nxt_s     = 1'b1;
      end else begin
         load_nxt_s = 1'b0;
      end
      locked_nxt_s = (state_nxt_s == ST_TRACK);
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         slip_cnt_r  <= 6'd0;
         hit_cnt_r   <= 8'd0;
         loss_cnt_r  <= 8'd0;
         blank_r     <= 1'b0;
         load_r      <= 1'b0;
         addr_load_r <= 8'd0;
         locked_r    <= 1'b0;
         wrap_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         slip_cnt_r  <= slip_cnt_nxt_s;
         hit_cnt_r   <= hit_cnt_nxt_s;
         loss_cnt_r  <= loss_cnt_nxt_s;
         blank_r     <= blank_nxt_s;
         load_r      <= load_nxt_s;
         addr_load_r <= addr_load_nxt_s;
         locked_r    <= locked_nxt_s;
         wrap_r      <= wrap_nxt_s;
      end
   end

   assign load        = load_r;
   assign addr_load   = addr_load_r;
   assign locked      = locked_r;
   assign state       = state_r;
   assign search_wrap = wrap_r;

endmodule
